// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - fetch/decode/execute/writeback sequencer driving an 8-bit ALU and 4x8 register file
// Optional feature macro: ALU_SEQ_BRANCH_EN (op 1000 becomes branch-if-zero).
module alu_sequencer #(
  parameter int         PC_W    = 8,
  parameter int         NREG    = 4,
  parameter logic [3:0] HALT_OP = 4'b1111
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [PC_W-1:0] instr_addr,
  input  logic [15:0]     instr_data,
  output logic [3:0]      alu_opcode,
  output logic [7:0]      alu_a,
  output logic [7:0]      alu_b,
  output logic [7:0]      alu_load_number,
  input  logic [7:0]      alu_out,
  input  logic [3:0]      alu_flag,
  output logic [3:0]      flag_q,
  output logic            busy,
  output logic            halted,
  input  logic [1:0]      dbg_sel,
  output logic [7:0]      dbg_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
  } state_t;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [3:0]      ir_op;
  logic [1:0]      ir_rd;
  logic [7:0]      ir_imm;
  logic [7:0]      res_q;
  logic [3:0]      res_flag;
  logic [7:0]      regs [NREG];

  assign instr_addr = pc;
  assign dbg_data   = regs[dbg_sel];

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      pc              <= '0;
      flag_q          <= '0;
      busy            <= 1'b0;
      halted          <= 1'b0;
      alu_opcode      <= 4'b1111;
      alu_a           <= '0;
      alu_b           <= '0;
      alu_load_number <= '0;
      ir_op           <= '0;
      ir_rd           <= '0;
      ir_imm          <= '0;
      res_q           <= '0;
      res_flag        <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            pc     <= '0;
            busy   <= 1'b1;
            halted <= 1'b0;
            state  <= S_FETCH;
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          // Operands are read here, so rd==rs both see the pre-write value.
          ir_op           <= instr_data[15:12];
          ir_rd           <= instr_data[11:10];
          ir_imm          <= instr_data[7:0];
          alu_a           <= regs[instr_data[11:10]];
          alu_b           <= regs[instr_data[9:8]];
          alu_load_number <= instr_data[7:0];
          alu_opcode      <= instr_data[15:12];
          state           <= S_EXECUTE;
        end
        S_EXECUTE: begin
          res_q      <= alu_out;
          res_flag   <= alu_flag;
          alu_opcode <= 4'b1111;
          state      <= S_WRITEBACK;
        end
        S_WRITEBACK: begin
          if (ir_op == HALT_OP) begin
            busy   <= 1'b0;
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            state <= S_FETCH;
            pc    <= pc + PC_W'(1);
            if (ir_op <= 4'b0110) begin
              regs[ir_rd] <= res_q;
              flag_q      <= res_flag;
            end else if (ir_op == 4'b1110) begin
              regs[ir_rd] <= ir_imm;
            end
`ifdef ALU_SEQ_BRANCH_EN
            else if (ir_op == 4'b1000 && flag_q[1]) begin
              pc <= PC_W'(ir_imm);
            end
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench: instruction-level model, per-cycle compare, random programs
module tb_alu_sequencer;

`ifdef ALU_SEQ_BRANCH_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  instr_addr;
  logic [15:0] instr_data;
  logic [3:0]  alu_opcode;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  alu_load_number;
  logic [7:0]  alu_out;
  logic [3:0]  alu_flag;
  logic [3:0]  flag_q;
  logic        busy;
  logic        halted;
  logic [1:0]  dbg_sel;
  logic [7:0]  dbg_data;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .instr_addr(instr_addr), .instr_data(instr_data),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_load_number(alu_load_number), .alu_out(alu_out), .alu_flag(alu_flag),
    .flag_q(flag_q), .busy(busy), .halted(halted),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  // Synchronous ROM: data follows the address by one clock.
  logic [15:0] rom [256];
  always @(posedge clk) instr_data <= rom[instr_addr];

  // ALU: flags {carry, negative, zero-of-9-bit-result, 0}.
  function automatic logic [11:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] r;
    case (op)
      4'd0:    r = {1'b0, a} + {1'b0, b};
      4'd1:    r = {1'b0, a} - {1'b0, b};
      4'd2:    r = {1'b0, a & b};
      4'd3:    r = {1'b0, a | b};
      4'd4:    r = {1'b0, a ^ b};
      4'd5:    r = {a, 1'b0};
      4'd6:    r = {a[0], 1'b0, a[7:1]};
      default: r = '0;
    endcase
    return {r[8], r[7], (r == 9'd0), 1'b0, r[7:0]};
  endfunction

  always_comb {alu_flag, alu_out} = alu_fn(alu_opcode, alu_a, alu_b);

  // Architectural model
  logic [7:0] m_reg [4];
  logic [7:0] m_pc;
  logic [3:0] m_flag;
  logic       m_run;
  logic       m_halt;
  int         phase;
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
    m_pc = 8'h00; m_flag = 4'h0; m_run = 1'b0; m_halt = 1'b0; phase = 0;
  endtask

  task automatic model_exec();
    logic [15:0] ins;
    logic [11:0] r;
    logic [7:0]  nxt;
    ins = rom[m_pc];
    if (ins[15:12] == 4'hF) begin
      m_halt = 1'b1;
      m_run  = 1'b0;
    end else begin
      nxt = m_pc + 8'd1;
      if (ins[15:12] <= 4'd6) begin
        r = alu_fn(ins[15:12], m_reg[ins[11:10]], m_reg[ins[9:8]]);
        m_reg[ins[11:10]] = r[7:0];
        m_flag = r[11:8];
      end else if (ins[15:12] == 4'hE) begin
        m_reg[ins[11:10]] = ins[7:0];
      end else if (BR_EN && ins[15:12] == 4'h8 && m_flag[1]) begin
        nxt = ins[7:0];
      end
      m_pc = nxt;
    end
  endtask

  // One clock: sample inputs at the edge, advance the model, compare outputs.
  task automatic tick();
    logic rs, ss;
    logic [15:0] ins;
    @(posedge clk);
    rs = rst; ss = start;
    #1;
    if (rs) model_reset();
    else if (ss && !m_run) begin
      m_pc = 8'h00; m_run = 1'b1; m_halt = 1'b0; phase = 0;
    end else if (m_run) begin
      phase++;
      if (phase == 4) begin
        phase = 0;
        model_exec();
      end
    end
    chk("instr_addr", instr_addr, m_pc);
    chk("busy", busy, m_run);
    chk("halted", halted, m_halt);
    chk("flag_q", flag_q, m_flag);
    ins = rom[m_pc];
    if (m_run && phase == 2) begin
      chk("exec_opcode", alu_opcode, ins[15:12]);
      chk("alu_a", alu_a, m_reg[ins[11:10]]);
      chk("alu_b", alu_b, m_reg[ins[9:8]]);
      chk("alu_load_number", alu_load_number, ins[7:0]);
    end else begin
      chk("idle_opcode", alu_opcode, 4'b1111);
    end
  endtask

  task automatic read_reg(input int r, output logic [7:0] v);
    dbg_sel = 2'(r);
    #1;
    v = dbg_data;
  endtask

  task automatic check_regs();
    logic [7:0] v;
    for (int r = 0; r < 4; r++) begin
      read_reg(r, v);
      chk("dbg_reg", v, m_reg[r]);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
  endtask

  task automatic run_prog(input int bound, input logic [7:0] watch, output int cycles,
                          output logic [3:0] w_flag, output logic [7:0] w_dbg);
    logic seen;
    seen = 1'b0; w_flag = 'x; w_dbg = 'x;
    start = 1'b1; tick(); start = 1'b0;
    cycles = 0;
    while (!halted && cycles < bound) begin
      tick();
      cycles++;
      if (!seen && instr_addr == watch) begin
        seen = 1'b1; w_flag = flag_q; w_dbg = dbg_data;
      end
    end
    chk("halt_reached", halted, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         cyc;
    logic [3:0] wf;
    logic [7:0] wd;
    logic [7:0] v;
    logic       seen;
    logic [3:0] op;
    int         n;

    clear_rom();
    rst = 1'b1; start = 1'b0; dbg_sel = 2'd0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_addr", instr_addr, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_flag", flag_q, 4'h0);
    chk("rst_opcode", alu_opcode, 4'b1111);
    chk("rst_alu_a", alu_a, 8'h00);
    chk("rst_alu_b", alu_b, 8'h00);
    chk("rst_load", alu_load_number, 8'h00);
    for (int r = 0; r < 4; r++) begin
      read_reg(r, v);
      chk("rst_reg", v, 8'h00);
    end

    // LDI R0,FF; LDI R1,01; ADD R0,R1; HALT
    clear_rom();
    rom[0] = 16'hE0FF; rom[1] = 16'hE401; rom[2] = 16'h0100; rom[3] = 16'hF000;
    run_prog(100, 8'hEE, cyc, wf, wd);
    chk("progA_cycles", cyc, 16);
    chk("progA_flag", flag_q, 4'b1000);
    chk("progA_addr", instr_addr, 8'h03);
    read_reg(0, v); chk("progA_r0", v, 8'h00);
    read_reg(1, v); chk("progA_r1", v, 8'h01);
    check_regs();

    // LDI R2,5; LDI R3,5; SUB R2,R3; XOR R2,R3; HALT (R0/R1 must be retained)
    clear_rom();
    rom[0] = 16'hE805; rom[1] = 16'hEC05; rom[2] = 16'h1B00; rom[3] = 16'h4B00; rom[4] = 16'hF000;
    dbg_sel = 2'd2;
    run_prog(100, 8'h03, cyc, wf, wd);
    chk("sub_flag", wf, 4'b0010);
    chk("sub_r2", wd, 8'h00);
    read_reg(2, v); chk("xor_r2", v, 8'h05);
    chk("xor_flag", flag_q, 4'b0000);
    read_reg(0, v); chk("retain_r0", v, 8'h00);
    read_reg(1, v); chk("retain_r1", v, 8'h01);
    check_regs();

    // SUB to zero then BZ 0x10
    clear_rom();
    rom[0] = 16'hE805; rom[1] = 16'hEC05; rom[2] = 16'h1B00; rom[3] = 16'h8010;
    run_prog(100, 8'hEE, cyc, wf, wd);
    chk("bz_taken_addr", instr_addr, BR_EN ? 8'h10 : 8'h04);
    check_regs();

    // SUB nonzero then BZ 0x10 falls through
    clear_rom();
    rom[0] = 16'hE805; rom[1] = 16'hEC03; rom[2] = 16'h1B00; rom[3] = 16'h8010;
    run_prog(100, 8'hEE, cyc, wf, wd);
    chk("bz_fall_addr", instr_addr, 8'h04);
    read_reg(2, v); chk("bz_fall_r2", v, 8'h02);
    check_regs();

    // PC wrap: 255 random non-branch instructions, no-op at 255, HALT at 0 after wrap
    for (int i = 0; i < 255; i++) begin
      op = 4'($urandom_range(0, 14));
      if (op == 4'h8) op = 4'h7;
      rom[i] = {op, 12'($urandom)};
    end
    rom[255] = 16'h7000;
    start = 1'b1; tick(); start = 1'b0;
    n = 0; seen = 1'b0;
    while (!halted && n < 1200) begin
      if (n == 10) rom[0] = 16'hF000;
      start = (n == 50);
      tick();
      n++;
      if (instr_addr == 8'hFF) seen = 1'b1;
    end
    start = 1'b0;
    chk("wrap_halt", halted, 1'b1);
    chk("wrap_seen_ff", seen, 1'b1);
    chk("wrap_addr", instr_addr, 8'h00);
    chk("wrap_cycles", n, 1028);
    check_regs();

    // Random programs with forward-only branches
    for (int t = 0; t < 4; t++) begin
      clear_rom();
      for (int i = 0; i < 31; i++) begin
        op = 4'($urandom_range(0, 14));
        if (op == 4'h8) rom[i] = {op, 4'($urandom), 8'(i + 1 + $urandom_range(0, 30 - i))};
        else            rom[i] = {op, 12'($urandom)};
      end
      run_prog(200, 8'hEE, cyc, wf, wd);
      check_regs();
    end

    // Reset in the middle of EXECUTE
    clear_rom();
    rom[0] = 16'hE0AA; rom[1] = 16'h0000;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("pre_rst_opcode", alu_opcode, 4'h0);
    chk("pre_rst_alu_a", alu_a, 8'hAA);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_addr", instr_addr, 8'h00);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_flag", flag_q, 4'h0);
    chk("mid_rst_opcode", alu_opcode, 4'b1111);
    chk("mid_rst_alu_a", alu_a, 8'h00);
    for (int r = 0; r < 4; r++) begin
      read_reg(r, v);
      chk("mid_rst_reg", v, 8'h00);
    end

    // start together with rst: rst wins
    rst = 1'b1; start = 1'b1; tick(); rst = 1'b0; start = 1'b0;
    tick(); tick();
    chk("rst_start_busy", busy, 1'b0);
    chk("rst_start_addr", instr_addr, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
